// File: rtl/bcd_scan_display_if.sv
// Bus between a BCD counter chain (master) and the scanned 7-segment driver (slave).
// There is no valid/ready pair here. latch is a level strobe sampled on every rising clk,
// and bcd_in is captured on any edge where latch=1. seg, dig_sel and frame are registered outputs of the slave.
interface bcd_scan_display_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_in;
    logic                latch;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   dig_sel;
    logic                frame;

    modport master (output bcd_in, latch, input seg, dig_sel, frame);
    modport slave  (input bcd_in, latch, output seg, dig_sel, frame);
endinterface

// File: rtl/bcd_scan_display.sv
// Captures a packed BCD word on latch and scans it digit by digit onto one 7-segment bus.
// Optional leading-zero blanking is enabled by defining LZB_EN.
module bcd_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DIV_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    bcd_scan_display_if.slave   bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] snapshot;
    logic [DIV_W-1:0]    prescaler;
    logic [IDX_W-1:0]    scan_idx;
    logic [3:0]          cur_digit;
    logic [DIGITS-1:0]   cur_sel;
    logic                blank;
    logic [6:0]          cur_seg;

    // Segment order {g,f,e,d,c,b,a}; codes above 9 show a bare dash.
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    always_comb begin
        cur_digit = 4'd0;
        cur_sel   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                cur_digit  = snapshot[4*k +: 4];
                cur_sel[k] = 1'b1;
            end
        end
    end

`ifdef LZB_EN
    // lead_zero[k]: digit k and every more significant digit are zero.
    logic [DIGITS:0] lead_zero;
    always_comb begin
        lead_zero         = '0;
        lead_zero[DIGITS] = 1'b1;
        blank             = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead_zero[k] = lead_zero[k+1] && (snapshot[4*k +: 4] == 4'd0);
            if (k > 0 && scan_idx == IDX_W'(k) && lead_zero[k])
                blank = 1'b1;
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign cur_seg = blank ? 7'd0 : decode(cur_digit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot    <= '0;
            prescaler   <= '0;
            scan_idx    <= '0;
            bus.seg     <= '0;
            bus.dig_sel <= '0;
            bus.frame   <= 1'b0;
        end else begin
            if (bus.latch)
                snapshot <= bus.bcd_in;
            if (prescaler == DIV_TC) begin
                prescaler <= '0;
                scan_idx  <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            bus.seg     <= cur_seg;
            bus.dig_sel <= cur_sel;
            // Wrap is seen as the last digit lit while the index already points at digit 0.
            bus.frame   <= (scan_idx == '0) && bus.dig_sel[DIGITS-1];
        end
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (DIGITS=4, SCAN_DIV=4); honours LZB_EN if defined.
module tb_bcd_scan_display;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int DIV_W    = 3;
  localparam int FRAME    = DIGITS * SCAN_DIV;
`ifdef LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [15:0] bcd;
    logic [27:0] plain;  // {d3,d2,d1,d0} segments, no blanking
    logic [27:0] lzb;    // same with leading-zero blanking
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  // Reference model: edges since reset release and the snapshot value.
  int          n = 0;
  logic [15:0] m_snap = '0;

  always #5 clk = ~clk;

  bcd_scan_display_if #(.DIGITS(DIGITS)) bus ();

  bcd_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_tab(input logic [3:0] c);
    logic [6:0] t [16];
    t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
          7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    return t[c];
  endfunction

  function automatic logic [6:0] seg_of(input int d, input logic [15:0] v);
    logic [15:0] upper;
    upper = v >> (4 * d);
    if (LZB && d > 0 && upper == 16'd0) return 7'd0;
    return seg_tab(upper[3:0]);
  endfunction

  // One clock: update the model at the edge, then compare all outputs 1 time unit later.
  task automatic step(input string tag);
    logic [15:0] snap_before;
    int d;
    @(posedge clk);
    snap_before = m_snap;
    if (bus.latch) m_snap = bus.bcd_in;
    n++;
    d = ((n - 1) / SCAN_DIV) % DIGITS;
    #1;
    chk({tag, "_dig"},   32'(bus.dig_sel), 32'(1 << d));
    chk({tag, "_seg"},   32'(bus.seg),     32'(seg_of(d, snap_before)));
    chk({tag, "_frame"}, 32'(bus.frame),   32'((n > 1) && ((n - 1) % FRAME == 0)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_seg",   32'(bus.seg),     32'd0);
    chk("rst_dig",   32'(bus.dig_sel), 32'd0);
    chk("rst_frame", 32'(bus.frame),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    n      = 0;
    m_snap = '0;
  endtask

  vec_t        vecs [4];
  logic [6:0]  got [DIGITS];
  logic [3:0]  t1_dig [17];
  logic [27:0] exp_all;
  int          lit_cnt;

  initial begin
    vecs[0] = '{16'h1985, {7'b0000110, 7'b1101111, 7'b1111111, 7'b1101101},
                          {7'b0000110, 7'b1101111, 7'b1111111, 7'b1101101}};
    vecs[1] = '{16'h00A3, {7'b0111111, 7'b0111111, 7'b1000000, 7'b1001111},
                          {7'b0000000, 7'b0000000, 7'b1000000, 7'b1001111}};
    vecs[2] = '{16'h0000, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111},
                          {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}};
    vecs[3] = '{16'h0709, {7'b0111111, 7'b0000111, 7'b0111111, 7'b1101111},
                          {7'b0000000, 7'b0000111, 7'b0111111, 7'b1101111}};
    t1_dig = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
               4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
               4'b0001};

    bus.bcd_in = '0;
    bus.latch  = 1'b0;
    rst        = 1'b0;
    #2;
    do_reset();

    // T1: scan order, slot length and frame position.
    for (int i = 0; i < 17; i++) begin
      step("t1");
      chk("t1_seq",   32'(bus.dig_sel), 32'(t1_dig[i]));
      chk("t1_fpos",  32'(bus.frame),   32'(i == 16));
    end

    // T2..T4: latch a word, clear the inputs, read every digit slot over a full frame.
    foreach (vecs[v]) begin
      bus.bcd_in = vecs[v].bcd;
      bus.latch  = 1'b1;
      step("tab_latch");
      bus.bcd_in = '0;
      bus.latch  = 1'b0;
      for (int d = 0; d < DIGITS; d++) got[d] = 7'h7f;
      for (int c = 0; c < FRAME; c++) begin
        step("tab_run");
        for (int d = 0; d < DIGITS; d++)
          if (bus.dig_sel == 4'(1 << d)) got[d] = bus.seg;
      end
      exp_all = LZB ? vecs[v].lzb : vecs[v].plain;
      for (int d = 0; d < DIGITS; d++)
        chk($sformatf("tab%0d_d%0d", v, d), 32'(got[d]), 32'(exp_all[7*d +: 7]));
    end

    // T5: reset while digit 2 is lit mid-slot, then a full digit-0 slot.
    do_reset();
    bus.bcd_in = 16'h4321;
    bus.latch  = 1'b1;
    repeat (10) step("t5_pre");
    bus.latch = 1'b0;
    chk("t5_mid_dig", 32'(bus.dig_sel), 32'b0100);
    do_reset();
    lit_cnt = 0;
    for (int i = 0; i < SCAN_DIV + 1; i++) begin
      step("t5_post");
      if (bus.dig_sel == 4'b0001) lit_cnt++;
    end
    chk("t5_slot_len", 32'(lit_cnt), 32'(SCAN_DIV));
    chk("t5_snap_cleared", 32'(bus.seg), 32'(seg_of(1, 16'h0000)));

    // T6: latch on the prescaler terminal edge shows up in the very next slot.
    do_reset();
    bus.bcd_in = 16'h1111;
    bus.latch  = 1'b1;
    step("t6_a");
    bus.latch = 1'b0;
    step("t6_b");
    step("t6_c");
    bus.bcd_in = 16'h2222;
    bus.latch  = 1'b1;
    step("t6_tc");
    bus.latch  = 1'b0;
    bus.bcd_in = '0;
    step("t6_next");
    chk("t6_dig", 32'(bus.dig_sel), 32'b0010);
    chk("t6_seg", 32'(bus.seg),     32'(7'b1011011));

    // Random latches and digit values, including illegal codes and zero runs.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] w;
      for (int d = 0; d < DIGITS; d++)
        w[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.bcd_in = w;
      bus.latch  = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
